line_deserializer: RTL and testbench

//   Parametrised successor to the fixed 8x32 fill deserializer. Assembles a cache

---
 rtl/line_deserializer.sv | 168 ++++++++++++++++
 tb/tb_line_deserializer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_deserializer.sv
// -----------------------------------------------------------------------------
// line_deserializer
//
// Assembles one cache line from WORDS beats of WORD_W bits that arrive on a
// valid/ready word stream. The first beat may target any word slot; subsequent
// beats fill the following slots and wrap from WORDS-1 back to 0. This matches
// critical-word-first fills. The first accepted beat of every fill is also
// forwarded on crit_data with a one-cycle crit_valid pulse, so the requester
// can be woken before the whole line is present. A finished line is held on
// line_data and stays stable until the consumer takes it. flush aborts
// whatever is in flight.
//
// The design sits between the memory-side fill port and the data-array write
// port of the cache.
//
// Parameters
//   WORD_W  bits per beat (>= 8)
//   WORDS   beats per line (power of two, >= 2)
//   IDX_W   word index width, derived from WORDS; leave it at its default
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous abort; has the highest priority in every state
//   start_valid  request to begin a line fill
//   start_idx    slot index of the first (critical) beat
//   start_ready  high only while idle
//   in_valid     incoming beat valid
//   in_data      incoming beat
//   in_ready     high only while filling
//   crit_valid   one-cycle pulse after the first beat of a fill is accepted
//   crit_data    copy of that first beat
//   line_valid   assembled line is available
//   line_data    assembled line; word k sits at [k*WORD_W +: WORD_W]
//   line_ready   consumer accepts the held line
//   busy         high whenever the block is not idle
// -----------------------------------------------------------------------------
module line_deserializer #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 8,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    start_valid,
  input  logic [IDX_W-1:0]        start_idx,
  output logic                    start_ready,
  input  logic                    in_valid,
  input  logic [WORD_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    crit_valid,
  output logic [WORD_W-1:0]       crit_data,
  output logic                    line_valid,
  output logic [WORD_W*WORDS-1:0] line_data,
  input  logic                    line_ready,
  output logic                    busy
);

  // cnt must be able to count up to WORDS, so it is one bit wider than ptr.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WORD_W-1:0]  words_q [WORDS];
  logic [WORD_W-1:0]  crit_data_q;
  logic               crit_valid_q;

  // Next-value helpers for the datapath counters.
  logic [IDX_W-1:0]   ptr_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               beat_fire;
  logic               first_beat;
  logic               last_beat;

  // WORDS is a power of two, so the plain IDX_W-bit increment already gives
  // the WORDS-1 -> 0 wrap that critical-word-first bursts need.
  assign ptr_d      = ptr_q + 1'b1;
  assign cnt_d      = cnt_q + 1'b1;
  assign beat_fire  = (state_q == ST_FILL) && in_valid;
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LAST_CNT);

  // All status outputs are decoded from the state register only, so none of
  // them has a combinational path from an input.
  assign start_ready = (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_FILL);
  assign line_valid  = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign crit_valid  = crit_valid_q;
  assign crit_data   = crit_data_q;

  // Flatten the word array onto the line bus.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_pack
      assign line_data[gi*WORD_W +: WORD_W] = words_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      crit_data_q  <= '0;
      crit_valid_q <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        words_q[k] <= '0;
      end
    end else begin
      // crit_valid is a one-cycle pulse. By default it drops every cycle.
      crit_valid_q <= 1'b0;

      if (flush) begin
        // The abort discards any beat or start in this cycle. Words that were
        // already written stay in the array; only the control state is cleared.
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_valid) begin
              ptr_q   <= start_idx;
              cnt_q   <= '0;
              state_q <= ST_FILL;
            end
          end

          ST_FILL: begin
            if (beat_fire) begin
              words_q[ptr_q] <= in_data;
              ptr_q          <= ptr_d;
              cnt_q          <= cnt_d;
              if (first_beat) begin
                crit_data_q  <= in_data;
                crit_valid_q <= 1'b1;
              end
              if (last_beat) begin
                state_q <= ST_HOLD;
              end
            end
          end

          ST_HOLD: begin
            // The line leaves on the handshake. A new start can only be seen
            // from IDLE, so it is taken one cycle later at the earliest.
            if (line_ready) begin
              state_q <= ST_IDLE;
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_deserializer.sv
// -----------------------------------------------------------------------------
// tb_line_deserializer
//
// Directed bench for line_deserializer. dut_a is the default 8 x 32-bit
// instance. dut_b is a 4 x 64-bit instance that gets the in-order and
// wrap-around fills. Inputs are driven 1 time unit after each rising edge, and
// outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_line_deserializer;

  logic clk;
  logic rst_n;

  // 8 x 32 instance
  logic         a_flush, a_start_valid, a_start_ready, a_in_valid, a_in_ready;
  logic [2:0]   a_start_idx;
  logic [31:0]  a_in_data, a_crit_data;
  logic         a_crit_valid, a_line_valid, a_line_ready, a_busy;
  logic [255:0] a_line_data;

  // 4 x 64 instance
  logic         b_flush, b_start_valid, b_start_ready, b_in_valid, b_in_ready;
  logic [1:0]   b_start_idx;
  logic [63:0]  b_in_data, b_crit_data;
  logic         b_crit_valid, b_line_valid, b_line_ready, b_busy;
  logic [255:0] b_line_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] exp_line;
  logic [255:0] prev_line;

  line_deserializer #(.WORD_W(32), .WORDS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .start_valid(a_start_valid), .start_idx(a_start_idx), .start_ready(a_start_ready),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .crit_valid(a_crit_valid), .crit_data(a_crit_data),
    .line_valid(a_line_valid), .line_data(a_line_data), .line_ready(a_line_ready),
    .busy(a_busy)
  );

  line_deserializer #(.WORD_W(64), .WORDS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .start_valid(b_start_valid), .start_idx(b_start_idx), .start_ready(b_start_ready),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .crit_valid(b_crit_valid), .crit_data(b_crit_data),
    .line_valid(b_line_valid), .line_data(b_line_data), .line_ready(b_line_ready),
    .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_start(input logic [2:0] idx);
    a_start_idx   = idx;
    a_start_valid = 1'b1;
    step();
    a_start_valid = 1'b0;
  endtask

  // Drive eight back-to-back beats starting at base, with no checks.
  task automatic a_beats(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = base + 32'(i);
      step();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic a_release();
    a_line_ready = 1'b1;
    step();
    a_line_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (a_start_ready !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready got=%b exp=1", a_start_ready); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", a_in_ready); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    n_cmp++; if (a_line_valid !== 1'b0) begin n_bad++; $display("FAIL reset_line_valid got=%b exp=0", a_line_valid); end
    n_cmp++; if (a_crit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_crit_valid got=%b exp=0", a_crit_valid); end
    n_cmp++; if (a_line_data !== 256'h0) begin n_bad++; $display("FAIL reset_line_data got=%h exp=0", a_line_data); end
    n_cmp++; if (a_crit_data !== 32'h0) begin n_bad++; $display("FAIL reset_crit_data got=%h exp=0", a_crit_data); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    $display("txn reset done");
  endtask

  // T1: start slot 0, beats 0..7 with no gaps.
  task automatic test_in_order();
    a_start(3'd0);
    n_cmp++; if (a_in_ready !== 1'b1 || a_start_ready !== 1'b0 || a_busy !== 1'b1) begin n_bad++; $display("FAIL t1_fill_flags got in_ready=%b start_ready=%b busy=%b exp 1/0/1", a_in_ready, a_start_ready, a_busy); end
    exp_line = '0;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(i);
      exp_line[i*32 +: 32] = 32'(i);
      step();
      if (i == 0) begin
        n_cmp++; if (a_crit_valid !== 1'b1 || a_crit_data !== 32'h0) begin n_bad++; $display("FAIL t1_crit got valid=%b data=%h exp 1/0", a_crit_valid, a_crit_data); end
      end
      if (i == 1) begin
        n_cmp++; if (a_crit_valid !== 1'b0) begin n_bad++; $display("FAIL t1_crit_pulse got=%b exp=0", a_crit_valid); end
      end
      if (i == 6) begin
        n_cmp++; if (a_line_valid !== 1'b0) begin n_bad++; $display("FAIL t1_early_line_valid got=%b exp=0", a_line_valid); end
      end
    end
    a_in_valid = 1'b0;
    n_cmp++; if (a_line_valid !== 1'b1) begin n_bad++; $display("FAIL t1_line_valid got=%b exp=1", a_line_valid); end
    n_cmp++; if (a_line_data !== exp_line) begin n_bad++; $display("FAIL t1_line_data got=%h exp=%h", a_line_data, exp_line); end
    a_release();
    n_cmp++; if (a_line_valid !== 1'b0 || a_start_ready !== 1'b1) begin n_bad++; $display("FAIL t1_release got line_valid=%b start_ready=%b exp 0/1", a_line_valid, a_start_ready); end
    $display("txn t1 in-order fill line=%h", a_line_data);
  endtask

  // T2: start slot 5, beats A0..A7 wrap to slots 5,6,7,0,1,2,3,4.
  task automatic test_wrap();
    a_start(3'd5);
    exp_line = '0;
    for (int i = 0; i < 8; i++) begin
      exp_line[((5 + i) % 8)*32 +: 32] = 32'hA0 + 32'(i);
    end
    a_beats(32'hA0);
    n_cmp++; if (a_line_valid !== 1'b1) begin n_bad++; $display("FAIL t2_line_valid got=%b exp=1", a_line_valid); end
    n_cmp++; if (a_line_data !== exp_line) begin n_bad++; $display("FAIL t2_line_data got=%h exp=%h", a_line_data, exp_line); end
    n_cmp++; if (a_crit_data !== 32'hA0) begin n_bad++; $display("FAIL t2_crit_data got=%h exp=a0", a_crit_data); end
    a_release();
    $display("txn t2 wrap fill idx=5 line=%h", a_line_data);
  endtask

  // T3: in_valid alternates 1/0; line is complete after 16 cycles.
  task automatic test_gaps();
    a_start(3'd0);
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'(i);
    for (int c = 0; c < 16; c++) begin
      if (c < 15) begin
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL t3_in_ready cycle=%0d got=%b exp=1", c, a_in_ready); end
      end
      a_in_valid = ((c % 2) == 0);
      a_in_data  = (c % 2 == 0) ? 32'(c / 2) : 32'hFFFF_FFFF;
      step();
    end
    a_in_valid = 1'b0;
    n_cmp++; if (a_line_valid !== 1'b1) begin n_bad++; $display("FAIL t3_line_valid got=%b exp=1", a_line_valid); end
    n_cmp++; if (a_line_data !== exp_line) begin n_bad++; $display("FAIL t3_line_data got=%h exp=%h", a_line_data, exp_line); end
    $display("txn t3 gapped fill line=%h", a_line_data);
  endtask

  // T4: continues from T3's held line; consumer stalls for 10 cycles while
  // stray starts and beats are offered.
  task automatic test_hold();
    a_start_valid = 1'b1;
    a_in_valid    = 1'b1;
    a_in_data     = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++; if (a_line_valid !== 1'b1 || a_line_data !== exp_line) begin n_bad++; $display("FAIL t4_hold_line cycle=%0d got valid=%b data=%h exp 1/%h", c, a_line_valid, a_line_data, exp_line); end
      n_cmp++; if (a_start_ready !== 1'b0 || a_in_ready !== 1'b0) begin n_bad++; $display("FAIL t4_hold_ready cycle=%0d got start_ready=%b in_ready=%b exp 0/0", c, a_start_ready, a_in_ready); end
    end
    a_in_valid = 1'b0;
    // The handshake cycle also presents a start, which must not be taken yet.
    a_line_ready = 1'b1;
    step();
    a_line_ready = 1'b0;
    n_cmp++; if (a_line_valid !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL t4_release got line_valid=%b busy=%b exp 0/0", a_line_valid, a_busy); end
    step();
    a_start_valid = 1'b0;
    n_cmp++; if (a_busy !== 1'b1 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL t4_back_to_back_start got busy=%b in_ready=%b exp 1/1", a_busy, a_in_ready); end
    // Finish this fill to leave the block idle.
    a_beats(32'h0);
    a_release();
    $display("txn t4 hold and back-to-back start done");
  endtask

  // T5: flush after beat 3, then a clean fill starting at slot 2.
  task automatic test_flush();
    prev_line = a_line_data;
    a_start(3'd0);
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'hB0 + 32'(i);
      step();
    end
    a_flush   = 1'b1;
    a_in_data = 32'hDEAD_0004;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    n_cmp++; if (a_busy !== 1'b0 || a_start_ready !== 1'b1 || a_line_valid !== 1'b0 || a_crit_valid !== 1'b0) begin n_bad++; $display("FAIL t5_flush_state got busy=%b start_ready=%b line_valid=%b crit_valid=%b exp 0/1/0/0", a_busy, a_start_ready, a_line_valid, a_crit_valid); end
    n_cmp++; if (a_line_data[3*32 +: 32] !== 32'hB3) begin n_bad++; $display("FAIL t5_kept_word3 got=%h exp=b3", a_line_data[3*32 +: 32]); end
    n_cmp++; if (a_line_data[4*32 +: 32] !== prev_line[4*32 +: 32]) begin n_bad++; $display("FAIL t5_dropped_beat got=%h exp=%h", a_line_data[4*32 +: 32], prev_line[4*32 +: 32]); end
    step();
    n_cmp++; if (a_line_valid !== 1'b0 || a_busy !== 1'b0) begin n_bad++; $display("FAIL t5_still_idle got line_valid=%b busy=%b exp 0/0", a_line_valid, a_busy); end
    a_start(3'd2);
    exp_line = '0;
    for (int i = 0; i < 8; i++) exp_line[((2 + i) % 8)*32 +: 32] = 32'hC0 + 32'(i);
    a_beats(32'hC0);
    n_cmp++; if (a_line_valid !== 1'b1 || a_line_data !== exp_line) begin n_bad++; $display("FAIL t5_refill got valid=%b data=%h exp 1/%h", a_line_valid, a_line_data, exp_line); end
    n_cmp++; if (a_crit_data !== 32'hC0) begin n_bad++; $display("FAIL t5_refill_crit got=%h exp=c0", a_crit_data); end
    a_release();
    $display("txn t5 flush then refill idx=2 line=%h", a_line_data);
  endtask

  // T6: asynchronous reset between edges during a fill.
  task automatic test_async_reset();
    a_start(3'd0);
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h55 + 32'(i);
      step();
    end
    a_in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_busy !== 1'b0 || a_in_ready !== 1'b0 || a_start_ready !== 1'b1) begin n_bad++; $display("FAIL t6_async_flags got busy=%b in_ready=%b start_ready=%b exp 0/0/1", a_busy, a_in_ready, a_start_ready); end
    n_cmp++; if (a_line_data !== 256'h0 || a_crit_data !== 32'h0) begin n_bad++; $display("FAIL t6_async_data got line=%h crit=%h exp 0/0", a_line_data, a_crit_data); end
    #2;
    rst_n = 1'b1;
    step();
    n_cmp++; if (a_busy !== 1'b0 || a_line_valid !== 1'b0) begin n_bad++; $display("FAIL t6_after_release got busy=%b line_valid=%b exp 0/0", a_busy, a_line_valid); end
    $display("txn t6 async reset mid-fill");
  endtask

  // WORDS=4, WORD_W=64 instance: in-order and wrap-around fills.
  task automatic test_small();
    for (int pass = 0; pass < 2; pass++) begin
      logic [1:0] idx;
      idx = (pass == 0) ? 2'd0 : 2'd3;
      b_start_idx   = idx;
      b_start_valid = 1'b1;
      step();
      b_start_valid = 1'b0;
      exp_line = '0;
      for (int i = 0; i < 4; i++) begin
        b_in_valid = 1'b1;
        b_in_data  = 64'h1111_2222_0000_0000 + 64'(pass * 16 + i);
        exp_line[((int'(idx) + i) % 4)*64 +: 64] = b_in_data;
        step();
        if (i == 0) begin
          n_cmp++; if (b_crit_valid !== 1'b1 || b_crit_data !== (64'h1111_2222_0000_0000 + 64'(pass * 16))) begin n_bad++; $display("FAIL small_crit pass=%0d got valid=%b data=%h", pass, b_crit_valid, b_crit_data); end
        end
      end
      b_in_valid = 1'b0;
      n_cmp++; if (b_line_valid !== 1'b1 || b_line_data !== exp_line) begin n_bad++; $display("FAIL small_line pass=%0d got valid=%b data=%h exp 1/%h", pass, b_line_valid, b_line_data, exp_line); end
      b_line_ready = 1'b1;
      step();
      b_line_ready = 1'b0;
      n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL small_release pass=%0d got busy=%b exp=0", pass, b_busy); end
      $display("txn small fill idx=%0d line=%h", idx, b_line_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_start_valid = 1'b0; a_start_idx = '0; a_in_valid = 1'b0; a_in_data = '0; a_line_ready = 1'b0;
    b_flush = 1'b0; b_start_valid = 1'b0; b_start_idx = '0; b_in_valid = 1'b0; b_in_data = '0; b_line_ready = 1'b0;
    test_reset();
    test_in_order();
    test_wrap();
    test_gaps();
    test_hold();
    test_flush();
    test_async_reset();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
